// File: rtl/spi_bank_scheduler.sv
// Shares one SPI read stream between the video and audio banks.
// Define SCHED_TIMEOUT_EN to bound the header hunt and flag hdr_timeout.
module spi_bank_scheduler #(
  parameter logic [7:0]  HEADER      = 8'hFF,
  parameter int unsigned VIDEO_BYTES = 38400,
  parameter int unsigned AUDIO_BYTES = 512,
  parameter int unsigned HDR_TIMEOUT = 4096,
  parameter int unsigned CS_GAP      = 8
) (
  input  logic       CLK_40,
  input  logic       reset,
  input  logic       SPI_clk_en,
  input  logic       MISO,
  input  logic       frame_done,
  input  logic       audio_low,
  input  logic       video_bank_full,
  input  logic       audio_bank_full,
  output logic       chip_select,
  output logic       write_video,
  output logic       write_audio,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       hdr_timeout
);

  localparam logic [15:0] VQ   = 16'(VIDEO_BYTES);
  localparam logic [15:0] AQ   = 16'(AUDIO_BYTES);
  localparam logic [15:0] GLIM = 16'(CS_GAP - 1);

  typedef enum logic [1:0] {IDLE, HUNT, XFER, GAP} state_e;

  state_e      state_q;
  logic        vid_pend_q;
  logic        last_audio_q;
  logic        gnt_audio_q;
  logic [7:0]  sh_q;
  logic [2:0]  bit_q;
  logic [15:0] cnt_q;
  logic        cs_q;
  logic        wv_q;
  logic        wa_q;
  logic [7:0]  dout_q;
  logic        busy_q;

  logic [7:0]  sh_d;
  logic        grant_audio;
  logic        grant_full;
  logic        gnt_full;
  logic [15:0] quota;

  assign sh_d        = {sh_q[6:0], MISO};
  assign grant_audio = audio_low & (~vid_pend_q | ~last_audio_q);
  assign grant_full  = grant_audio ? audio_bank_full : video_bank_full;
  assign gnt_full    = gnt_audio_q ? audio_bank_full : video_bank_full;
  assign quota       = gnt_audio_q ? AQ : VQ;

`ifdef SCHED_TIMEOUT_EN
  localparam logic [15:0] HLIM = 16'(HDR_TIMEOUT - 1);
  logic [15:0] hunt_q;
  logic        to_q;
  assign hdr_timeout = to_q;
`else
  assign hdr_timeout = 1'b0;
`endif

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state_q      <= IDLE;
      vid_pend_q   <= 1'b0;
      last_audio_q <= 1'b0;
      gnt_audio_q  <= 1'b0;
      sh_q         <= '0;
      bit_q        <= '0;
      cnt_q        <= '0;
      cs_q         <= 1'b1;
      wv_q         <= 1'b0;
      wa_q         <= 1'b0;
      dout_q       <= '0;
      busy_q       <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      hunt_q       <= '0;
      to_q         <= 1'b0;
`endif
    end else begin
      wv_q <= 1'b0;
      wa_q <= 1'b0;
      if (frame_done) vid_pend_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (vid_pend_q || audio_low) begin
            gnt_audio_q  <= grant_audio;
            last_audio_q <= grant_audio;
            if (!grant_audio) vid_pend_q <= frame_done;
            busy_q <= 1'b1;
            sh_q   <= '0;
            bit_q  <= '0;
            cnt_q  <= '0;
`ifdef SCHED_TIMEOUT_EN
            hunt_q <= '0;
`endif
            // A bank that is already full gets no select, just the gap
            if (grant_full) begin
              state_q <= GAP;
            end else begin
              cs_q    <= 1'b0;
              state_q <= HUNT;
            end
          end
        end
        HUNT: begin
          if (SPI_clk_en) begin
            sh_q <= sh_d;
            if (sh_d == HEADER) begin
              bit_q   <= '0;
              state_q <= XFER;
            end
`ifdef SCHED_TIMEOUT_EN
            else if (hunt_q == HLIM) begin
              to_q    <= 1'b1;
              cs_q    <= 1'b1;
              cnt_q   <= '0;
              state_q <= GAP;
              if (!gnt_audio_q) vid_pend_q <= 1'b1;
            end else begin
              hunt_q <= hunt_q + 16'd1;
            end
`endif
          end
        end
        XFER: begin
          // Checked every cycle: a full flag drops any partial byte
          if (gnt_full || cnt_q == quota) begin
            cs_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= GAP;
          end else if (SPI_clk_en) begin
            sh_q  <= sh_d;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              dout_q <= sh_d;
              wv_q   <= ~gnt_audio_q;
              wa_q   <= gnt_audio_q;
              cnt_q  <= cnt_q + 16'd1;
            end
          end
        end
        GAP: begin
          if (SPI_clk_en) begin
            if (cnt_q == GLIM) begin
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
      endcase
    end
  end

  assign chip_select = cs_q;
  assign write_video = wv_q;
  assign write_audio = wa_q;
  assign data_out    = dout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_bank_scheduler.sv
// Scoreboard bench for spi_bank_scheduler: directed SPI streams,
// expected bank writes queued and checked by a separate monitor.
module tb_spi_bank_scheduler;

  localparam int CS_GAP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       miso;
  logic       frame_done;
  logic       audio_low;
  logic       vfull;
  logic       afull;
  logic       cs;
  logic       wv;
  logic       wa;
  logic [7:0] dout;
  logic       busy;
  logic       hto;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  spi_bank_scheduler #(
    .HEADER(8'hFF),
    .VIDEO_BYTES(4),
    .AUDIO_BYTES(8),
    .HDR_TIMEOUT(32),
    .CS_GAP(CS_GAP)
  ) dut (
    .CLK_40(clk),
    .reset(reset),
    .SPI_clk_en(en),
    .MISO(miso),
    .frame_done(frame_done),
    .audio_low(audio_low),
    .video_bank_full(vfull),
    .audio_bank_full(afull),
    .chip_select(cs),
    .write_video(wv),
    .write_audio(wa),
    .data_out(dout),
    .busy(busy),
    .hdr_timeout(hto)
  );

  always @(negedge clk) begin
    if (wv || wa) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stray_strobe got wv=%0b wa=%0b data=%02h exp none",
                 wv, wa, dout);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({wa, wv, dout} !== {e[8], ~e[8], e[7:0]}) begin
          n_fail++;
          $display("FAIL bank_write got wa=%0b wv=%0b data=%02h exp wa=%0b data=%02h",
                   wa, wv, dout, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    miso = b;
    en   = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic expect_byte(input logic aud, input logic [7:0] b);
    exp_q.push_back({aud, b});
  endtask

  task automatic send_last(input string nm, input logic [7:0] b);
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    miso = b[0];
    en   = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk({nm, "_strobe"}, 32'(wv | wa), 32'd1);
    chk({nm, "_cs_held"}, 32'(cs), 32'd0);
    @(negedge clk);
    chk({nm, "_cs_rise"}, 32'(cs), 32'd1);
  endtask

  task automatic gap_check(input string nm);
    for (int i = 0; i < CS_GAP; i++) begin
      miso = 1'b0;
      en   = 1'b1;
      @(negedge clk);
      en = 1'b0;
      if (i < CS_GAP - 1) begin
        chk({nm, "_gap_busy"}, 32'(busy), 32'd1);
        chk({nm, "_gap_cs"}, 32'(cs), 32'd1);
      end else begin
        chk({nm, "_gap_end"}, 32'(busy), 32'd0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset      = 1'b1;
    en         = 1'b0;
    miso       = 1'b0;
    frame_done = 1'b0;
    audio_low  = 1'b0;
    vfull      = 1'b0;
    afull      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_wv", 32'(wv), 32'd0);
    chk("rst_wa", 32'(wa), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hto", 32'(hto), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Video only
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    chk("vid_pend_cycle_cs", 32'(cs), 32'd1);
    @(negedge clk);
    chk("vid_grant_cs", 32'(cs), 32'd0);
    chk("vid_grant_busy", 32'(busy), 32'd1);
    expect_byte(1'b0, 8'hA5);
    expect_byte(1'b0, 8'h3C);
    expect_byte(1'b0, 8'h00);
    expect_byte(1'b0, 8'hFF);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(8'h00);
    send_last("vid_last", 8'hFF);
    gap_check("vid");
    chk("vid_idle_cs", 32'(cs), 32'd1);

    // Both pending: audio first, unaligned header
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    audio_low  = 1'b1;
    @(negedge clk);
    chk("both_grant_cs", 32'(cs), 32'd0);
    for (int i = 0; i < 8; i++) expect_byte(1'b1, 8'(8'h11 * (i + 1)));
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h11 * (i + 1)));
    send_last("aud_last", 8'h88);
    gap_check("aud");
    chk("alt_video_cs", 32'(cs), 32'd0);
    expect_byte(1'b0, 8'h5A);
    expect_byte(1'b0, 8'hC3);
    expect_byte(1'b0, 8'h0F);
    expect_byte(1'b0, 8'hF0);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h0F);
    send_last("alt_vid_last", 8'hF0);
    gap_check("alt_vid");
    chk("alt_audio_cs", 32'(cs), 32'd0);

    // Audio bank fills mid 4th byte
    expect_byte(1'b1, 8'hC1);
    expect_byte(1'b1, 8'hC2);
    expect_byte(1'b1, 8'hC3);
    send_byte(8'hFF);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    afull     = 1'b1;
    audio_low = 1'b0;
    @(negedge clk);
    chk("full_cs_rise", 32'(cs), 32'd1);
    gap_check("full");
    afull = 1'b0;

    // Bank already full at grant
    afull     = 1'b1;
    audio_low = 1'b1;
    @(negedge clk);
    audio_low = 1'b0;
    chk("prefull_cs", 32'(cs), 32'd1);
    chk("prefull_busy", 32'(busy), 32'd1);
    gap_check("prefull");
    afull = 1'b0;

    // Reset in the middle of a byte
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    @(negedge clk);
    chk("rstx_grant_cs", 32'(cs), 32'd0);
    expect_byte(1'b0, 8'hD1);
    expect_byte(1'b0, 8'hD2);
    send_byte(8'hFF);
    send_byte(8'hD1);
    send_byte(8'hD2);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstx_cs", 32'(cs), 32'd1);
    chk("rstx_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    send_byte(8'hE7);
    chk("rstx_after_cs", 32'(cs), 32'd1);
    chk("rstx_after_busy", 32'(busy), 32'd0);

`ifdef SCHED_TIMEOUT_EN
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    @(negedge clk);
    chk("to_grant_cs", 32'(cs), 32'd0);
    for (int i = 0; i < 31; i++) send_bit(1'b0);
    chk("to_not_yet", 32'(hto), 32'd0);
    send_bit(1'b0);
    chk("to_flag", 32'(hto), 32'd1);
    chk("to_cs", 32'(cs), 32'd1);
    gap_check("to");
    chk("to_retry_cs", 32'(cs), 32'd0);
    chk("to_sticky", 32'(hto), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("to_cleared", 32'(hto), 32'd0);
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
